// File: rtl/cache_perf_pkg.sv
// Shared definitions for the cache performance counter bank: event channel
// indices, default channel count and small index/width helpers.
package cache_perf_pkg;

  typedef enum logic [2:0] {
    EV_HIT       = 3'd0,
    EV_MISS      = 3'd1,
    EV_READ      = 3'd2,
    EV_WRITE     = 3'd3,
    EV_WRITEBACK = 3'd4
  } cache_event_e;

  localparam int NUM_CACHE_EVENTS = 5;

  // Read-select width; a single channel still gets a one-bit select.
  function automatic int sel_width(input int num_events);
    return (num_events > 1) ? $clog2(num_events) : 1;
  endfunction

  // Low bit of channel idx inside the flat shadow bus.
  function automatic int shadow_lsb(input int idx, input int xlen);
    return idx * xlen;
  endfunction

endpackage

// File: rtl/cache_perf_counters_if.sv
// Bus between the cache controller (master) and the counter bank (slave):
// event pulses, control strobes, the read port and the shadow value bus.
interface cache_perf_counters_if
  import cache_perf_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_CACHE_EVENTS,
  parameter int XLEN       = 32
);
  localparam int SEL_W = sel_width(NUM_EVENTS);

  // No handshake: every strobe acts on the edge it is sampled high, and a
  // read select issued in cycle n returns rd_data in cycle n+1, every cycle.
  logic [NUM_EVENTS-1:0]      event_i;
  logic                       count_en;
  logic                       clear;
  logic                       snapshot;
  logic [SEL_W-1:0]           rd_sel;
  logic                       rd_shadow;
  logic [XLEN-1:0]            rd_data;
  logic [NUM_EVENTS-1:0]      overflow;
  logic [NUM_EVENTS*XLEN-1:0] shadow_values;

  modport master (
    output event_i, count_en, clear, snapshot, rd_sel, rd_shadow,
    input  rd_data, overflow, shadow_values
  );

  modport slave (
    input  event_i, count_en, clear, snapshot, rd_sel, rd_shadow,
    output rd_data, overflow, shadow_values
  );

endinterface

// File: rtl/perf_counter.sv
// One performance counter channel: live count, shadow copy and a sticky
// overflow flag, with clear taking priority over increment.
module perf_counter #(
  parameter int XLEN     = 32,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            clear,
  input  logic            snapshot,
  output logic [XLEN-1:0] live,
  output logic [XLEN-1:0] shadow,
  output logic            overflow
);

  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] OVF_VAL = (SATURATE != 0) ? {XLEN{1'b1}} : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live     <= '0;
      shadow   <= '0;
      overflow <= 1'b0;
    end else begin
      // Shadow samples the pre-edge live value, so snapshot+clear is a
      // race-free read-and-reset.
      if (snapshot) shadow <= live;
      if (clear) begin
        live     <= '0;
        overflow <= 1'b0;
      end else if (inc) begin
        if (&live) begin
          live     <= OVF_VAL;
          overflow <= 1'b1;
        end else begin
          live <= live + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/cache_perf_counters.sv
// Cache performance counter bank: NUM_EVENTS independent channels, a
// registered indexed read port and the flat shadow value bus.
module cache_perf_counters
  import cache_perf_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_CACHE_EVENTS,
  parameter int XLEN       = 32,
  parameter int SATURATE   = 0
) (
  input logic                  clk,
  input logic                  reset,
  cache_perf_counters_if.slave bus
);

  localparam int SEL_W  = sel_width(NUM_EVENTS);
  localparam int NSLOTS = 2 ** SEL_W;

  // Unused select codes map to zero-valued slots, so no range check is needed.
  logic [XLEN-1:0] live_arr   [NSLOTS];
  logic [XLEN-1:0] shadow_arr [NSLOTS];
  logic [XLEN-1:0] rd_next;

  for (genvar i = 0; i < NSLOTS; i++) begin : g_ch
    if (i < NUM_EVENTS) begin : g_real
      logic ovf;
      perf_counter #(
        .XLEN     (XLEN),
        .SATURATE (SATURATE)
      ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (bus.count_en & bus.event_i[i]),
        .clear    (bus.clear),
        .snapshot (bus.snapshot),
        .live     (live_arr[i]),
        .shadow   (shadow_arr[i]),
        .overflow (ovf)
      );
      assign bus.overflow[i] = ovf;
      assign bus.shadow_values[shadow_lsb(i, XLEN) +: XLEN] = shadow_arr[i];
    end else begin : g_pad
      assign live_arr[i]   = '0;
      assign shadow_arr[i] = '0;
    end
  end

  always_comb begin
    rd_next = bus.rd_shadow ? shadow_arr[bus.rd_sel] : live_arr[bus.rd_sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.rd_data <= '0;
    else       bus.rd_data <= rd_next;
  end

endmodule

// File: tb/tb_cache_perf_counters.sv
// Bench for cache_perf_counters: a wrap and a saturate instance (XLEN=4) get
// identical stimulus and are checked against a reference model and queue.
module tb_cache_perf_counters;
  import cache_perf_pkg::*;

  localparam int N = NUM_CACHE_EVENTS;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_perf_counters_if #(.NUM_EVENTS(N), .XLEN(W)) if_w ();
  cache_perf_counters_if #(.NUM_EVENTS(N), .XLEN(W)) if_s ();

  cache_perf_counters #(.NUM_EVENTS(N), .XLEN(W), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .bus(if_w.slave)
  );
  cache_perf_counters #(.NUM_EVENTS(N), .XLEN(W), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .bus(if_s.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_w_q[$];
  logic [W-1:0] exp_s_q[$];

  // Reference model, index 0 = wrap instance, 1 = saturate instance.
  logic [W-1:0] m_live   [2][N];
  logic [W-1:0] m_shadow [2][N];
  logic [N-1:0] m_ovf    [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_ovf[v] = '0;
      for (int i = 0; i < N; i++) begin
        m_live[v][i]   = '0;
        m_shadow[v][i] = '0;
      end
    end
  endtask

  function automatic logic [W-1:0] model_read(input int v, input int sel, input bit shd);
    if (sel >= N) return '0;
    return shd ? m_shadow[v][sel] : m_live[v][sel];
  endfunction

  function automatic logic [N*W-1:0] model_flat(input int v);
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_shadow[v][i];
    return f;
  endfunction

  task automatic model_step(input logic [N-1:0] ev, input bit en, input bit clr, input bit snap);
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N; i++) begin
        if (snap) m_shadow[v][i] = m_live[v][i];
        if (clr) begin
          m_live[v][i] = '0;
          m_ovf[v][i]  = 1'b0;
        end else if (en && ev[i]) begin
          if (m_live[v][i] == 4'hF) begin
            m_ovf[v][i]  = 1'b1;
            m_live[v][i] = (v == 1) ? 4'hF : 4'h0;
          end else begin
            m_live[v][i] = m_live[v][i] + 4'd1;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] ev, input bit en, input bit clr, input bit snap,
                       input int sel, input bit shd);
    if_w.event_i = ev;  if_s.event_i = ev;
    if_w.count_en = en; if_s.count_en = en;
    if_w.clear = clr;   if_s.clear = clr;
    if_w.snapshot = snap; if_s.snapshot = snap;
    if_w.rd_sel = 3'(sel); if_s.rd_sel = 3'(sel);
    if_w.rd_shadow = shd;  if_s.rd_shadow = shd;
  endtask

  // One clock: drive at negedge, expect pre-edge read, compare at next negedge.
  task automatic step(input logic [N-1:0] ev, input bit en, input bit clr, input bit snap,
                      input int sel, input bit shd);
    drive(ev, en, clr, snap, sel, shd);
    exp_w_q.push_back(model_read(0, sel, shd));
    exp_s_q.push_back(model_read(1, sel, shd));
    model_step(ev, en, clr, snap);
    @(posedge clk);
    @(negedge clk);
    check("rd_wrap", 32'(if_w.rd_data), 32'(exp_w_q.pop_front()));
    check("rd_sat", 32'(if_s.rd_data), 32'(exp_s_q.pop_front()));
    check("ovf_wrap", 32'(if_w.overflow), 32'(m_ovf[0]));
    check("ovf_sat", 32'(if_s.overflow), 32'(m_ovf[1]));
    check("shadow_wrap", 32'(if_w.shadow_values), 32'(model_flat(0)));
    check("shadow_sat", 32'(if_s.shadow_values), 32'(model_flat(1)));
  endtask

  task automatic pulses(input int ch, input int n);
    logic [N-1:0] ev;
    ev = '0;
    ev[ch] = 1'b1;
    repeat (n) step(ev, 1'b1, 1'b0, 1'b0, ch, 1'b0);
  endtask

  task automatic idle_read(input int sel, input bit shd);
    step('0, 1'b1, 1'b0, 1'b0, sel, shd);
  endtask

  logic [N*W-1:0] flat;

  initial begin
    reset = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd", 32'(if_w.rd_data), 32'd0);
    check("reset_ovf", 32'(if_s.overflow), 32'd0);
    check("reset_shadow", 32'(if_w.shadow_values), 32'd0);
    reset = 1'b0;

    // Mid-count asynchronous reset with live[0]=7.
    pulses(int'(EV_HIT), 7);
    step('0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("pre_reset_rd", 32'(if_w.rd_data), 32'd7);
    #2 reset = 1'b1;
    #1;
    check("async_rd_wrap", 32'(if_w.rd_data), 32'd0);
    check("async_rd_sat", 32'(if_s.rd_data), 32'd0);
    check("async_shadow", 32'(if_w.shadow_values), 32'd0);
    check("async_ovf", 32'(if_w.overflow), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    pulses(int'(EV_HIT), 3);
    idle_read(0, 1'b0);
    check("hit3", 32'(if_w.rd_data), 32'd3);

    // 17 pulses on channel 1: wrap to 1, saturate at 15.
    pulses(int'(EV_MISS), 17);
    idle_read(1, 1'b0);
    check("wrap_live1", 32'(if_w.rd_data), 32'd1);
    check("wrap_ovf1", 32'(if_w.overflow), 32'b00010);
    check("sat_live1", 32'(if_s.rd_data), 32'd15);
    step('0, 1'b1, 1'b1, 1'b0, 1, 1'b0);

    // 20 pulses on channel 2, then clear.
    pulses(int'(EV_READ), 20);
    idle_read(2, 1'b0);
    check("sat_live2", 32'(if_s.rd_data), 32'd15);
    check("sat_ovf2", 32'(if_s.overflow), 32'b00100);
    check("wrap_live2", 32'(if_w.rd_data), 32'd4);
    step('0, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    idle_read(2, 1'b0);
    check("clr_live2", 32'(if_s.rd_data), 32'd0);
    check("clr_ovf2", 32'(if_s.overflow), 32'd0);

    // Snapshot + clear + event on channel 3 with live[3]=9.
    pulses(int'(EV_WRITE), 9);
    step(5'b01000, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    check("sce_rd_pre", 32'(if_w.rd_data), 32'd9);
    flat = if_w.shadow_values;
    check("sce_shadow3", 32'(flat[3*W +: W]), 32'd9);
    idle_read(3, 1'b0);
    check("sce_live3", 32'(if_w.rd_data), 32'd0);

    // count_en low: events ignored, snapshot still works.
    pulses(int'(EV_WRITEBACK), 2);
    for (int k = 0; k < 10; k++) step('1, 1'b0, 1'b0, 1'b0, k % N, 1'b0);
    step('1, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    check("en0_live4", 32'(if_w.rd_data), 32'd2);
    flat = if_s.shadow_values;
    check("en0_shadow4", 32'(flat[4*W +: W]), 32'd2);

    // Read-select sweep over live and shadow, including unused codes.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        idle_read(k, s[0]);
        if (k >= N) check("oob_rd", 32'(if_s.rd_data), 32'd0);
      end
    end

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step(5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_perf_counters.md
# cache_perf_counters

Parametrised cache performance counter bank. Counts per-cycle event pulses from the cache controller (hit, miss, read, write, writeback by default) on `NUM_EVENTS` independent channels. Supports wrap or saturate overflow, sticky overflow flags, synchronous clear, an atomic snapshot into shadow registers, and an indexed registered read port. Sits beside the cache controller and drives the existing performance-interface value bus from its shadow registers.

## Interface
- `NUM_EVENTS`, 5, number of event channels (≥1)
- `XLEN`, 32, counter width in bits (≥2)
- `SATURATE`, 0, 0 = wrap on overflow; 1 = hold at all-ones
- `SEL_W`, `$clog2(NUM_EVENTS)` (min 1), read-select width (derived, not overridden)

- `clk` in 1: sole clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `event_i` in NUM_EVENTS: bit i high = one event on channel i this cycle
- `count_en` in 1: global count enable; events ignored when low
- `clear` in 1: synchronous clear of live counters and overflow flags
- `snapshot` in 1: copy live counters into shadow registers
- `rd_sel` in SEL_W: channel index for read port
- `rd_shadow` in 1: 1 = read shadow copy, 0 = read live counter
- `rd_data` out XLEN: registered read data
- `overflow` out NUM_EVENTS: sticky per-channel overflow flag
- `shadow_values` out NUM_EVENTS*XLEN: flat shadow bus, channel i at bits [i*XLEN +: XLEN]

## Operation
- Reset: live counters, shadows, `overflow`, `rd_data` all 0.
- Increment: if `count_en && event_i[i] && !clear`, live[i] increments by 1.
- Overflow at live[i] = all-ones plus increment:
  - SATURATE=0: live[i] becomes 0 and overflow[i] is set.
  - SATURATE=1: live[i] stays all-ones and overflow[i] is set.
- `overflow[i]` stays set until `clear` or `reset`.
- Clear: live counters and `overflow` become 0; shadows are untouched.
- Snapshot: every shadow[i] takes live[i]'s pre-edge value, all channels in the same edge (atomic).
- Read port:
  - `rd_data` ← selected live or shadow value, pre-edge.
  - `rd_sel ≥ NUM_EVENTS` returns 0.
- Simultaneous events:
  - `clear` + event: clear wins; the event is dropped.
  - `snapshot` + event: shadow gets the pre-increment value; live still increments.
  - `snapshot` + `clear`: shadow gets pre-clear values; live becomes 0. This gives a race-free read-and-reset.
  - Read of a live channel in the same cycle as its increment or clear: returns the pre-edge value.
- `count_en` gates increments only; `clear`, `snapshot` and read act regardless of it.
- No state machine; every channel is an independent registered counter with a priority update (clear > increment).

## Timing
- Event to live counter: 1 cycle; visible on `rd_data` 2 cycles after the event edge.
- `snapshot` to `shadow_values`: valid the cycle after the `snapshot` edge.
- Read latency: 1 cycle from `rd_sel`/`rd_shadow` to `rd_data`; a new selection every cycle is allowed (fully pipelined, no handshake).
- `overflow[i]` asserts in the same edge as the wrap/saturate update.
- `reset` asserted mid-operation: all outputs go to 0 immediately (asynchronously), independent of `clk`; first count occurs on the first edge after deassertion.

## Structure
- Package `cache_perf_pkg`:
  - event index enum `EV_HIT=0, EV_MISS=1, EV_READ=2, EV_WRITE=3, EV_WRITEBACK=4`
  - constant `NUM_CACHE_EVENTS = 5`
  - helper function returning the shadow slice for a given index
- Sub-module `perf_counter`, one channel: live counter, shadow, overflow flag, `SATURATE` behaviour. Instantiated `NUM_EVENTS` times in a generate loop.
- Top level holds only the read mux/register and the flat shadow bus.

## Test plan
- Reset: assert `reset` mid-count with live[0]=7 → all counters, shadows, `overflow`, `rd_data` read 0 at once; after release, 3 hit pulses → `rd_sel=0`, `rd_shadow=0` reads 3.
- Wrap (XLEN=4, SATURATE=0): 17 pulses on channel 1 → live[1]=1, `overflow[1]=1`, other overflow bits 0.
- Saturate (XLEN=4, SATURATE=1): 20 pulses on channel 2 → live[2]=15, `overflow[2]=1`; `clear` → live[2]=0, `overflow[2]=0`.
- Snapshot + clear + event same cycle (live[3]=9, `event_i[3]=1`) → shadow[3]=9 on `shadow_values[3*XLEN +: XLEN]`; live[3]=0.
- `count_en=0` with events on all channels for 10 cycles → all counts unchanged; `snapshot` still updates shadows.
- Read port:
  - `rd_sel` sweep 0..7 with NUM_EVENTS=5 → correct values with 1-cycle latency.
  - Indices 5–7 read 0.
